// File: rtl/mm_ctrl_pkg.sv
// Shared constants for the memory-stage controller: access-size codes, FSM states,
// and store strobe/data helpers.
package mm_ctrl_pkg;

    localparam logic [2:0] ACCESS_SZ_BYTE = 3'd0;
    localparam logic [2:0] ACCESS_SZ_HALF = 3'd1;
    localparam logic [2:0] ACCESS_SZ_WORD = 3'd2;

    typedef enum logic [1:0] {
        MM_IDLE = 2'd0,
        MM_REQ  = 2'd1,
        MM_WAIT = 2'd2,
        MM_DONE = 2'd3
    } mm_state_e;

    function automatic logic [1:0] bus_size(input logic [2:0] access_sz);
        case (access_sz)
            ACCESS_SZ_BYTE: bus_size = 2'd0;
            ACCESS_SZ_HALF: bus_size = 2'd1;
            default:        bus_size = 2'd2;
        endcase
    endfunction

    function automatic logic [3:0] store_strb(input logic [2:0] access_sz, input logic [1:0] offset);
        case (access_sz)
            ACCESS_SZ_BYTE: store_strb = 4'b0001 << offset;
            ACCESS_SZ_HALF: store_strb = 4'b0011 << {offset[1], 1'b0};
            default:        store_strb = 4'hF;
        endcase
    endfunction

    function automatic logic [31:0] store_data(input logic [2:0] access_sz, input logic [31:0] wdata);
        case (access_sz)
            ACCESS_SZ_BYTE: store_data = {4{wdata[7:0]}};
            ACCESS_SZ_HALF: store_data = {2{wdata[15:0]}};
            default:        store_data = wdata;
        endcase
    endfunction

endpackage

// File: rtl/mm_ctrl_if.sv
// Data-SRAM request bus (req/addr_ok/data_ok handshake) between mm_ctrl and the memory slave.
interface mm_ctrl_if;
    logic        data_sram_req;
    logic        data_sram_wr;
    logic [1:0]  data_sram_size;
    logic [3:0]  data_sram_wstrb;
    logic [31:0] data_sram_addr;
    logic [31:0] data_sram_wdata;
    logic        data_sram_addr_ok;
    logic        data_sram_data_ok;
    logic [31:0] data_sram_rdata;

    modport master (
        output data_sram_req, data_sram_wr, data_sram_size, data_sram_wstrb,
               data_sram_addr, data_sram_wdata,
        input  data_sram_addr_ok, data_sram_data_ok, data_sram_rdata
    );

    modport slave (
        input  data_sram_req, data_sram_wr, data_sram_size, data_sram_wstrb,
               data_sram_addr, data_sram_wdata,
        output data_sram_addr_ok, data_sram_data_ok, data_sram_rdata
    );
endinterface

// File: rtl/mm_ctrl_load_align.sv
// mm_load_align: moves the addressed byte/half of the read word to bit 0 and
// sign- or zero-extends it.
module mm_load_align
    import mm_ctrl_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  offset,
    input  logic [2:0]  access_sz,
    input  logic        ld_unsigned,
    output logic [31:0] data
);

    logic [31:0] shifted;

    always_comb begin
        shifted = rdata >> {offset, 3'b000};
        case (access_sz)
            ACCESS_SZ_BYTE: data = ld_unsigned ? {24'b0, shifted[7:0]}
                                               : {{24{shifted[7]}}, shifted[7:0]};
            ACCESS_SZ_HALF: data = ld_unsigned ? {16'b0, shifted[15:0]}
                                               : {{16{shifted[15]}}, shifted[15:0]};
            default:        data = shifted;
        endcase
    end

endmodule

// File: rtl/mm_ctrl.sv
// mm_ctrl: memory-stage responder for EX load/store requests over the data-SRAM bus.
// Build option: define MM_LLSC_EN to enable LL.W/SC.W llbit semantics.
module mm_ctrl
    import mm_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        ex_valid,
    output logic        mm_allowin,
    input  logic        mm_re,
    input  logic        mm_we,
    input  logic [31:0] mm_addr,
    input  logic [31:0] mm_wdata,
    input  logic [2:0]  mm_access_sz,
    input  logic        mm_ld_unsigned,
    input  logic        mm_ll,
    input  logic        mm_sc,
    input  logic        ex_ale,
    input  logic [31:0] exe_out,
    input  logic        reg_d_wen,
    input  logic        llbit_clr,
    mm_ctrl_if.master   bus,
    input  logic        wb_allowin,
    output logic        mm_out_valid,
    output logic [31:0] mm_out,
    output logic        mm_reg_d_wen,
    output logic        mm_ale
);

    mm_state_e   state;
    logic        lat_re;
    logic        lat_sc;
    logic        lat_unsigned;
    logic        lat_reg_wen;
    logic [2:0]  lat_sz;
    logic [1:0]  lat_off;
    logic [31:0] lat_exe;
    logic [31:0] load_data;
    logic [31:0] done_out;
    logic        done_wen;
    logic        accept;
    logic        mem_op;
    logic        sc_fail;
    logic        bus_done;

    mm_load_align u_load_align (
        .rdata       (bus.data_sram_rdata),
        .offset      (lat_off),
        .access_sz   (lat_sz),
        .ld_unsigned (lat_unsigned),
        .data        (load_data)
    );

    assign mm_allowin = (state == MM_IDLE);
    assign accept     = ex_valid && mm_allowin;
    assign mem_op     = mm_re || mm_we;
    assign bus_done   = ((state == MM_REQ) && bus.data_sram_addr_ok && bus.data_sram_data_ok)
                     || ((state == MM_WAIT) && bus.data_sram_data_ok);

`ifdef MM_LLSC_EN
    logic llbit;
    logic lat_ll;

    assign sc_fail  = mm_sc && !llbit;
    assign done_out = lat_sc ? 32'd1 : (lat_re ? load_data : lat_exe);
    assign done_wen = lat_sc ? 1'b1 : lat_reg_wen;

    // A clear request beats an LL completing in the same cycle.
    always_ff @(posedge clk) begin
        if (rst)
            llbit <= 1'b0;
        else if (llbit_clr || (accept && mm_sc))
            llbit <= 1'b0;
        else if (bus_done && lat_ll)
            llbit <= 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst)
            lat_ll <= 1'b0;
        else if (accept)
            lat_ll <= mm_ll;
    end
`else
    logic unused_llsc;

    assign sc_fail     = 1'b0;
    assign done_out    = lat_re ? load_data : lat_exe;
    assign done_wen    = lat_reg_wen && !lat_sc;
    assign unused_llsc = mm_ll ^ llbit_clr;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state                <= MM_IDLE;
            bus.data_sram_req    <= 1'b0;
            bus.data_sram_wr     <= 1'b0;
            bus.data_sram_size   <= 2'd0;
            bus.data_sram_wstrb  <= 4'd0;
            bus.data_sram_addr   <= 32'd0;
            bus.data_sram_wdata  <= 32'd0;
            mm_out_valid         <= 1'b0;
            mm_out               <= 32'd0;
            mm_reg_d_wen         <= 1'b0;
            mm_ale               <= 1'b0;
            lat_re               <= 1'b0;
            lat_sc               <= 1'b0;
            lat_unsigned         <= 1'b0;
            lat_reg_wen          <= 1'b0;
            lat_sz               <= 3'd0;
            lat_off              <= 2'd0;
            lat_exe              <= 32'd0;
        end else begin
            case (state)
                MM_IDLE: begin
                    if (accept) begin
                        lat_re              <= mm_re;
                        lat_sc              <= mm_sc;
                        lat_unsigned        <= mm_ld_unsigned;
                        lat_reg_wen         <= reg_d_wen;
                        lat_sz              <= mm_access_sz;
                        lat_off             <= mm_addr[1:0];
                        lat_exe             <= exe_out;
                        bus.data_sram_addr  <= mm_addr;
                        bus.data_sram_wr    <= mm_we;
                        bus.data_sram_size  <= bus_size(mm_access_sz);
                        bus.data_sram_wstrb <= mm_we ? store_strb(mm_access_sz, mm_addr[1:0]) : 4'd0;
                        bus.data_sram_wdata <= store_data(mm_access_sz, mm_wdata);
                        if (mem_op && !ex_ale && !sc_fail) begin
                            state             <= MM_REQ;
                            bus.data_sram_req <= 1'b1;
                        end else begin
                            // Non-memory ops, misaligned accesses and failed SCs skip the bus.
                            state        <= MM_DONE;
                            mm_out_valid <= 1'b1;
                            mm_out       <= (sc_fail && !ex_ale) ? 32'd0 : exe_out;
                            mm_reg_d_wen <= !ex_ale && (sc_fail || reg_d_wen);
                            mm_ale       <= ex_ale;
                        end
                    end
                end
                MM_REQ: begin
                    if (bus.data_sram_addr_ok) begin
                        bus.data_sram_req <= 1'b0;
                        state <= bus.data_sram_data_ok ? MM_DONE : MM_WAIT;
                    end
                end
                MM_WAIT: begin
                    if (bus.data_sram_data_ok)
                        state <= MM_DONE;
                end
                MM_DONE: begin
                    if (wb_allowin) begin
                        state        <= MM_IDLE;
                        mm_out_valid <= 1'b0;
                        mm_reg_d_wen <= 1'b0;
                        mm_ale       <= 1'b0;
                    end
                end
                default: state <= MM_IDLE;
            endcase

            if (bus_done) begin
                mm_out_valid <= 1'b1;
                mm_out       <= done_out;
                mm_reg_d_wen <= done_wen;
                mm_ale       <= 1'b0;
            end
        end
    end

endmodule
